// File: rtl/fifo_ctl_pkg.sv
// rtl/fifo_ctl_pkg.sv - shared constants and helpers for the FIFO controller
package fifo_ctl_pkg;

   localparam int ERR_STICKY = 0;
   localparam int ERR_CYCLE  = 1;

   // Smallest r such that 2**r >= n
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// rtl/fifo_ptr_wrap.sv - modulo-depth RAM address pointer
module fifo_ptr_wrap #(
   parameter int depth      = 8,
   parameter int addr_width = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inc,
   output logic [addr_width-1:0] ptr
);

   localparam logic [addr_width-1:0] L_LAST = addr_width'(depth - 1);

   logic [addr_width-1:0] r_ptr;

   // Advance on inc, wrapping from depth-1 back to 0 (depth need not be a power of two)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (inc) begin
         if (r_ptr == L_LAST) r_ptr <= '0;
         else                 r_ptr <= r_ptr + 1'b1;
      end
   end

   assign ptr = r_ptr;

endmodule

// File: rtl/fifo_ctl_r_w_a.sv
// rtl/fifo_ctl_r_w_a.sv - single-clock FIFO controller for an async-read FF RAM
module fifo_ctl_r_w_a
   import fifo_ctl_pkg::*;
#(
   parameter int depth      = 8,
   parameter int addr_width = 3,
   parameter int ae_level   = 2,
   parameter int af_level   = 2,
   parameter int err_mode   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_req,
   input  logic                  pop_req,
   output logic                  wr_n,
   output logic                  cs_n,
   output logic [addr_width-1:0] wr_addr,
   output logic [addr_width-1:0] rd_addr,
   output logic [addr_width:0]   word_count,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  half_full,
   output logic                  almost_full,
   output logic                  full,
   output logic                  error
);

   generate
      if (addr_width != clog2(depth)) begin : g_bad_addr_width
         $error("fifo_ctl_r_w_a: addr_width does not match depth");
      end
   endgenerate

   localparam logic [addr_width:0] L_DEPTH = (addr_width + 1)'(depth);
   localparam logic [addr_width:0] L_AE    = (addr_width + 1)'(ae_level);
   localparam logic [addr_width:0] L_HF    = (addr_width + 1)'((depth + 1) / 2);
   localparam logic [addr_width:0] L_AF    = (addr_width + 1)'(depth - af_level);

   logic [addr_width:0] r_count;
   logic                r_error;
   logic                w_push_acc;
   logic                w_pop_acc;
   logic                w_err_evt;

   // Acceptance is judged against the registered count, so requests never reach the flags combinationally
   assign w_push_acc = push_req & ~full;
   assign w_pop_acc  = pop_req  & ~empty;
   assign w_err_evt  = (push_req & full) | (pop_req & empty);

   // Strobe drops immediately while rst is high so no write can land during reset
   assign wr_n = ~(w_push_acc & ~rst);
   assign cs_n = wr_n;

   fifo_ptr_wrap #(.depth(depth), .addr_width(addr_width)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .inc (w_push_acc),
      .ptr (wr_addr)
   );

   fifo_ptr_wrap #(.depth(depth), .addr_width(addr_width)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .inc (w_pop_acc),
      .ptr (rd_addr)
   );

   // Occupancy: a simultaneous accepted push and pop cancel out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else begin
         case ({w_push_acc, w_pop_acc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Error either latches until reset or mirrors the previous cycle's event
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_error <= 1'b0;
      end else if (err_mode == ERR_CYCLE) begin
         r_error <= w_err_evt;
      end else begin
         r_error <= r_error | w_err_evt;
      end
   end

   assign word_count   = r_count;
   assign empty        = (r_count == '0);
   assign almost_empty = (r_count <= L_AE);
   assign half_full    = (r_count >= L_HF);
   assign almost_full  = (r_count >= L_AF);
   assign full         = (r_count == L_DEPTH);
   assign error        = r_error;

endmodule

// File: tb/tb_fifo_ctl_r_w_a.sv
// tb/tb_fifo_ctl_r_w_a.sv - directed self-checking bench for fifo_ctl_r_w_a
module tb_fifo_ctl_r_w_a;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // DUT A: depth 8, sticky error, with RAM model
   logic       push_a = 0, pop_a = 0;
   logic [7:0] din_a  = 0;
   logic       wr_n_a, cs_n_a, e_a, ae_a, hf_a, af_a, f_a, err_a;
   logic [2:0] wa_a, ra_a;
   logic [3:0] cnt_a;
   logic [7:0] mem_a [8];
   logic [7:0] dout_a;

   fifo_ctl_r_w_a #(.depth(8), .addr_width(3), .ae_level(2), .af_level(2), .err_mode(0)) dut_a (
      .clk(clk), .rst(rst), .push_req(push_a), .pop_req(pop_a), .wr_n(wr_n_a), .cs_n(cs_n_a),
      .wr_addr(wa_a), .rd_addr(ra_a), .word_count(cnt_a), .empty(e_a), .almost_empty(ae_a),
      .half_full(hf_a), .almost_full(af_a), .full(f_a), .error(err_a));

   always @(posedge clk) if (!wr_n_a) mem_a[wa_a] <= din_a;
   assign dout_a = mem_a[ra_a];

   // DUT B: depth 8, per-cycle error
   logic       push_b = 0, pop_b = 0;
   logic       wr_n_b, cs_n_b, e_b, ae_b, hf_b, af_b, f_b, err_b;
   logic [2:0] wa_b, ra_b;
   logic [3:0] cnt_b;

   fifo_ctl_r_w_a #(.depth(8), .addr_width(3), .ae_level(2), .af_level(2), .err_mode(1)) dut_b (
      .clk(clk), .rst(rst), .push_req(push_b), .pop_req(pop_b), .wr_n(wr_n_b), .cs_n(cs_n_b),
      .wr_addr(wa_b), .rd_addr(ra_b), .word_count(cnt_b), .empty(e_b), .almost_empty(ae_b),
      .half_full(hf_b), .almost_full(af_b), .full(f_b), .error(err_b));

   // DUT C: depth 6
   logic       push_c = 0, pop_c = 0;
   logic       wr_n_c, cs_n_c, e_c, ae_c, hf_c, af_c, f_c, err_c;
   logic [2:0] wa_c, ra_c;
   logic [3:0] cnt_c;

   fifo_ctl_r_w_a #(.depth(6), .addr_width(3), .ae_level(2), .af_level(2), .err_mode(0)) dut_c (
      .clk(clk), .rst(rst), .push_req(push_c), .pop_req(pop_c), .wr_n(wr_n_c), .cs_n(cs_n_c),
      .wr_addr(wa_c), .rd_addr(ra_c), .word_count(cnt_c), .empty(e_c), .almost_empty(ae_c),
      .half_full(hf_c), .almost_full(af_c), .full(f_c), .error(err_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // flags for DUT A packed as {empty, almost_empty, half_full, almost_full, full}
   function automatic logic [4:0] flags_a();
      return {e_a, ae_a, hf_a, af_a, f_a};
   endfunction

   initial begin
      // Reset state
      #2;
      chk("rst_wa", wa_a, 0);
      chk("rst_ra", ra_a, 0);
      chk("rst_cnt", cnt_a, 0);
      chk("rst_flags", flags_a(), 5'b11000);
      chk("rst_err", err_a, 0);
      chk("rst_wr_n", wr_n_a, 1);
      chk("rst_cs_n", cs_n_a, 1);
      step;
      rst = 0;

      // Fill A with 0x11..0x88
      for (int i = 0; i < 8; i++) begin
         push_a = 1;
         din_a  = 8'((i + 1) * 8'h11);
         #1;
         chk("fill_wr_n", wr_n_a, 0);
         chk("fill_cs_n", cs_n_a, 0);
         chk("fill_wa", wa_a, i);
         step;
         chk("fill_cnt", cnt_a, i + 1);
         chk("fill_af", af_a, (i + 1) >= 6);
         chk("fill_hf", hf_a, (i + 1) >= 4);
         chk("fill_ae", ae_a, (i + 1) <= 2);
      end
      push_a = 0;
      #1;
      chk("full_flags", flags_a(), 5'b00111);
      chk("full_wa", wa_a, 0);
      chk("full_err", err_a, 0);
      chk("idle_wr_n", wr_n_a, 1);

      // Drain A
      for (int i = 0; i < 8; i++) begin
         chk("drain_ra", ra_a, i);
         chk("drain_data", dout_a, (i + 1) * 8'h11);
         chk("drain_empty", e_a, 0);
         pop_a = 1;
         step;
         chk("drain_cnt", cnt_a, 7 - i);
         chk("drain_err", err_a, 0);
      end
      pop_a = 0;
      chk("drained_ra", ra_a, 0);
      chk("drained_flags", flags_a(), 5'b11000);

      // Refill, then push+pop while full: push rejected, pop accepted
      push_a = 1;
      for (int i = 0; i < 8; i++) step;
      chk("refill_full", f_a, 1);
      pop_a = 1;
      #1;
      chk("pushfull_wr_n", wr_n_a, 1);
      step;
      push_a = 0;
      pop_a  = 0;
      chk("pushfull_cnt", cnt_a, 7);
      chk("pushfull_err", err_a, 1);
      chk("pushfull_wa", wa_a, 0);
      chk("pushfull_ra", ra_a, 1);
      step;
      step;
      chk("sticky_err", err_a, 1);

      // Pop down to 5, then reset mid-burst between edges
      pop_a = 1;
      step;
      step;
      pop_a = 0;
      chk("pre_rst_cnt", cnt_a, 5);
      push_a = 1;
      #1;
      chk("burst_wr_n", wr_n_a, 0);
      #2;
      rst = 1;
      #1;
      chk("async_wr_n", wr_n_a, 1);
      chk("async_cs_n", cs_n_a, 1);
      chk("async_cnt", cnt_a, 0);
      chk("async_wa", wa_a, 0);
      chk("async_ra", ra_a, 0);
      chk("async_flags", flags_a(), 5'b11000);
      chk("async_err", err_a, 0);
      push_a = 0;
      step;
      rst = 0;

      // Pop on empty with push: push accepted, error raised
      push_a = 1;
      pop_a  = 1;
      #1;
      chk("popempty_wr_n", wr_n_a, 0);
      step;
      push_a = 0;
      pop_a  = 0;
      chk("popempty_cnt", cnt_a, 1);
      chk("popempty_empty", e_a, 0);
      chk("popempty_err", err_a, 1);
      chk("popempty_ra", ra_a, 0);
      chk("popempty_wa", wa_a, 1);

      // DUT B: per-cycle error clears next cycle
      push_b = 1;
      for (int i = 0; i < 8; i++) step;
      chk("b_full", f_b, 1);
      pop_b = 1;
      step;
      push_b = 0;
      pop_b  = 0;
      chk("b_cnt", cnt_b, 7);
      chk("b_err_set", err_b, 1);
      step;
      chk("b_err_clr", err_b, 0);

      // DUT C: depth 6, hold count 3 through pointer wrap
      push_c = 1;
      for (int i = 0; i < 3; i++) step;
      chk("c_cnt3", cnt_c, 3);
      chk("c_flags3", {e_c, ae_c, hf_c, af_c, f_c}, 5'b00100);
      pop_c = 1;
      for (int k = 1; k <= 10; k++) begin
         step;
         chk("c_pair_cnt", cnt_c, 3);
         chk("c_pair_wa", wa_c, (3 + k) % 6);
         chk("c_pair_ra", ra_c, k % 6);
         chk("c_pair_flags", {e_c, ae_c, hf_c, af_c, f_c}, 5'b00100);
      end
      push_c = 0;
      pop_c  = 0;
      chk("c_err", err_c, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
